mul_div_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, sitting beside the ALU.
- Takes the same forwarded operands as the ALU and an M-extension funct3 opcode.
- Computes one result bit per cycle, with a fixed latency, and presents a registered result plus a one-cycle done pulse.
- The EX/MEM result mux consumes this result instead of the ALU output; the hazard unit stalls the pipeline while busy is high.

---
 rtl/rv32m_pkg.sv | 22 ++
 rtl/mul_div_unit.sv | 106 ++++++++++
 tb/tb_mul_div_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared RV32M opcode/state types, latency constant and negate helpers
package rv32m_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_t;
  localparam int MDU_SIZE    = 32;
  localparam int MDU_LATENCY = MDU_SIZE + 2;
  function automatic logic [63:0] mdu_neg(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction
  function automatic logic [63:0] mdu_cneg(input logic [63:0] x, input logic n);
    return n ? mdu_neg(x) : x;
  endfunction
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one bit per cycle, fixed Size+2 latency
// Ports: clk, rst_n (async active-low), start/op/a/b launch, flush abort,
//        busy while in flight, done one-cycle pulse with registered out.
module mul_div_unit
  import rv32m_pkg::*;
#(
  parameter int Size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [Size-1:0] a,
  input  logic [Size-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [Size-1:0] out
);
  localparam int CW = $clog2(Size);
  mdu_state_t        r_state, w_next;
  mdu_op_t           r_op, w_op;
  logic              r_sa, r_sb, r_dz, r_ovf, r_done;
  logic              w_sa, w_sb, w_launch, w_qb;
  logic [CW-1:0]     r_cnt;
  logic [Size-1:0]   r_a, r_ma, r_mb, r_quo, r_rem, r_out;
  logic [Size-1:0]   w_ma, w_mb, w_q, w_r, w_res;
  logic [2*Size-1:0] r_acc, w_prod;
  logic [Size:0]     w_sum, w_rs, w_diff;
  assign w_op     = mdu_op_t'(op);
  assign w_launch = (r_state == IDLE) && start && !flush;
  // Sign flags only exist for operands the opcode treats as signed
  assign w_sa = a[Size-1] & (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign w_sb = b[Size-1] & (w_op inside {OP_MULH, OP_DIV, OP_REM});
  // Magnitudes via a wide negate so the most-negative value yields 2^(Size-1) cleanly
  assign w_ma = Size'(mdu_cneg(64'($signed(a)), w_sa));
  assign w_mb = Size'(mdu_cneg(64'($signed(b)), w_sb));
  // Shift-add: multiplier sits in the low half and is consumed LSB-first
  assign w_sum = {1'b0, r_acc[2*Size-1:Size]} + (r_acc[0] ? {1'b0, r_ma} : '0);
  // Restoring divide: dividend bits are shifted out of r_quo as quotient bits enter
  assign w_rs   = {r_rem, r_quo[Size-1]};
  assign w_diff = w_rs - {1'b0, r_mb};
  assign w_qb   = !w_diff[Size];
  assign w_prod = (2*Size)'(mdu_cneg(64'(r_acc), r_sa ^ r_sb));
  assign w_q    = Size'(mdu_cneg(64'(r_quo), r_sa ^ r_sb));
  assign w_r    = Size'(mdu_cneg(64'(r_rem), r_sa));
  assign w_res  = r_op == OP_MUL ? w_prod[Size-1:0] :
                  !r_op[2]       ? w_prod[2*Size-1:Size] :
                  r_dz           ? (r_op[1] ? r_a : '1) :
                  r_ovf          ? (r_op[1] ? '0 : r_a) :
                  r_op[1]        ? w_r : w_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = flush              ? IDLE :
             r_state == IDLE    ? (start ? CALC : IDLE) :
             r_state == CALC    ? (r_cnt == CW'(Size - 1) ? FIX : CALC) : IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_done;
    out  = r_out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_MUL;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
      r_a    <= '0;
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == FIX) && !flush;
      if (w_launch) begin
        r_op  <= w_op;
        r_sa  <= w_sa;
        r_sb  <= w_sb;
        r_dz  <= b == '0;
        r_ovf <= (w_op inside {OP_DIV, OP_REM}) && (a == {1'b1, {(Size-1){1'b0}}}) && (&b);
        r_a   <= a;
        r_ma  <= w_ma;
        r_mb  <= w_mb;
        r_acc <= {{Size{1'b0}}, w_mb};
        r_quo <= w_ma;
        r_rem <= '0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_acc <= {w_sum, r_acc[Size-1:1]};
        r_quo <= {r_quo[Size-2:0], w_qb};
        r_rem <= w_qb ? w_diff[Size-1:0] : w_rs[Size-1:0];
        r_cnt <= r_cnt + 1'b1;
      end else if ((r_state == FIX) && !flush) begin
        r_out <= w_res;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import rv32m_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] out;
  int total = 0;
  int bad = 0;
  mul_div_unit #(.Size(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .out(out)
  );
  always #5 clk = ~clk;
  // Launches one op from a negedge and returns at the negedge of its done cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < MDU_LATENCY + 10) begin
      @(negedge clk);
      lat++;
    end
    res = out;
  endtask
  task automatic test_reset;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: busy=%b done=%b out=%h required 0 0 00000000", busy, done, out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b out=%h required 0 0 00000000", busy, done, out);
    end
  endtask
  task automatic test_mul_timing;
    int errs = 0;
    start = 1'b1; op = OP_MUL; a = 32'd7; b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) errs++;
      if (c == 5) begin
        start = 1'b1; op = OP_MULHU; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL mul_busy_window: %0d cycles off, required busy=1 done=0 in cycles 1..33", errs);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== 32'hFFFFFFEB) begin
      bad++;
      $display("FAIL mul_cycle34: done=%b busy=%b out=%h required 1 0 ffffffeb", done, busy, out);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== 32'hFFFFFFEB) begin
      bad++;
      $display("FAIL mul_after: done=%b busy=%b out=%h required 0 0 ffffffeb", done, busy, out);
    end
  endtask
  task automatic test_ops;
    logic [2:0]  t_op [12] = '{OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_REM, OP_DIVU,
                               OP_REMU, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_MUL};
    logic [31:0] t_a  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] t_b  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h80000000};
    logic [31:0] t_e  [12] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                               32'h80000000, 32'h0, 32'h0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 12; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], res, lat);
      total++;
      if (res !== t_e[i] || lat != MDU_LATENCY) begin
        bad++;
        $display("FAIL op_vec%0d op=%0d a=%h b=%h: out=%h lat=%0d required %h lat=%0d",
                 i, t_op[i], t_a[i], t_b[i], res, lat, t_e[i], MDU_LATENCY);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_flush;
    logic [31:0] prev, res;
    int lat;
    int seen = 0;
    do_op(OP_MULHU, 32'h00010000, 32'h00030000, res, lat);
    total++;
    if (res !== 32'h3) begin
      bad++;
      $display("FAIL flush_setup: out=%h required 00000003", res);
    end
    prev = 32'h3;
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle11: busy=%b done=%b required 0 0", busy, done);
    end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0 || out !== prev) begin
      bad++;
      $display("FAIL flush_quiet: active_cycles=%0d out=%h required 0 %h", seen, out, prev);
    end
    do_op(OP_MUL, 32'd3, 32'd4, res, lat);
    total++;
    if (res !== 32'd12 || lat != MDU_LATENCY) begin
      bad++;
      $display("FAIL flush_then_mul: out=%h lat=%0d required 0000000c lat=%0d", res, lat, MDU_LATENCY);
    end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0 || out !== 32'd12) begin
      bad++;
      $display("FAIL start_flush_same: active_cycles=%0d out=%h required 0 0000000c", seen, out);
    end
  endtask
  task automatic test_reset_mid_and_back_to_back;
    logic [31:0] res;
    int lat;
    start = 1'b1; op = OP_MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b out=%h required 0 0 00000000", busy, done, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(OP_REMU, 32'd9, 32'd4, res, lat);
    total++;
    if (res !== 32'd1 || lat != MDU_LATENCY) begin
      bad++;
      $display("FAIL b2b_first: out=%h lat=%0d required 00000001 lat=%0d", res, lat, MDU_LATENCY);
    end
    do_op(OP_MUL, 32'd2, 32'd3, res, lat);
    total++;
    if (res !== 32'd6 || lat != MDU_LATENCY) begin
      bad++;
      $display("FAIL b2b_second: out=%h lat=%0d required 00000006 lat=%0d", res, lat, MDU_LATENCY);
    end
  endtask
  initial begin
    test_reset;
    test_mul_timing;
    test_ops;
    test_flush;
    test_reset_mid_and_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
